// File: rtl/ipg_tx_sched.sv
// ipg_tx_sched: round-robin scheduler that shares the per-cycle IPG bit budget among message sources.
// Revision: 1.0
`default_nettype none

module ipg_tx_sched #(
    parameter  int NUM_SRC      = 3,
    parameter  int LEN_W        = 10,
    parameter  int MAX_MSG_BITS = 528,
    localparam int SRC_W        = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [6:0]               slot_len,
    input  logic [NUM_SRC-1:0]       src_req,
    input  logic [NUM_SRC*LEN_W-1:0] src_len,
    input  logic [NUM_SRC*64-1:0]    src_data,
    output logic [NUM_SRC-1:0]       src_take,
    output logic [6:0]               take_len,
    output logic [NUM_SRC-1:0]       src_done,
    output logic [NUM_SRC-1:0]       src_err,
    output logic [63:0]              tx_ipg_data,
    output logic [6:0]               tx_len,
    output logic                     tx_valid,
    output logic                     tx_last,
    output logic [SRC_W-1:0]         tx_src
);

    localparam int          CMP_W = (LEN_W > 7) ? LEN_W : 7;
    localparam logic [31:0] MAX_U = MAX_MSG_BITS;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    state_t             state_q,  state_d;
    logic [SRC_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [SRC_W-1:0]   sel_q,    sel_d;
    logic [LEN_W-1:0]   rem_q,    rem_d;
    logic [NUM_SRC-1:0] done_q,   done_d;
    logic [NUM_SRC-1:0] err_q,    err_d;
    logic [63:0]        tx_data_q, tx_data_d;
    logic [6:0]         tx_len_q,  tx_len_d;
    logic               tx_valid_q, tx_valid_d;
    logic               tx_last_q,  tx_last_d;
    logic [SRC_W-1:0]   tx_src_q,   tx_src_d;

    logic [LEN_W-1:0]   w_len_arr  [NUM_SRC];
    logic [63:0]        w_data_arr [NUM_SRC];

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_unpack
        assign w_len_arr[g]  = src_len[g*LEN_W +: LEN_W];
        assign w_data_arr[g] = src_data[g*64 +: 64];
    end

    // Round-robin pick: first requester at or after rr_ptr_q, modulo NUM_SRC.
    logic             w_found;
    logic [SRC_W-1:0] w_pick;
    logic [SRC_W:0]   w_sum;
    logic [SRC_W-1:0] w_idx;

    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_sum   = '0;
        w_idx   = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            w_sum = {1'b0, rr_ptr_q} + (SRC_W+1)'(k);
            if (w_sum >= (SRC_W+1)'(NUM_SRC)) begin
                w_sum = w_sum - (SRC_W+1)'(NUM_SRC);
            end
            w_idx = w_sum[SRC_W-1:0];
            if (!w_found && src_req[w_idx]) begin
                w_found = 1'b1;
                w_pick  = w_idx;
            end
        end
    end

    logic [LEN_W-1:0] w_pick_len;
    logic             w_len_bad;
    logic [SRC_W-1:0] w_next_ptr;

    assign w_pick_len = w_len_arr[w_pick];
    assign w_len_bad  = (w_pick_len == '0) || (32'(w_pick_len) > MAX_U);
    assign w_next_ptr = (w_pick == SRC_W'(NUM_SRC - 1)) ? '0 : w_pick + SRC_W'(1);

    // Chunk size: the slot is capped at one 64-bit window, then at the bits still owed.
    logic [6:0]       w_slot;
    logic [CMP_W-1:0] w_slot_c;
    logic [CMP_W-1:0] w_rem_c;
    logic [6:0]       w_n;
    logic [63:0]      w_mask;

    assign w_slot   = (slot_len > 7'd64) ? 7'd64 : slot_len;
    assign w_slot_c = CMP_W'(w_slot);
    assign w_rem_c  = CMP_W'(rem_q);
    assign w_n      = (w_slot_c < w_rem_c) ? w_slot : 7'(rem_q);
    assign w_mask   = ~(64'hFFFF_FFFF_FFFF_FFFF >> w_n);

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        sel_d      = sel_q;
        rem_d      = rem_q;
        done_d     = '0;
        err_d      = '0;
        tx_data_d  = tx_data_q;
        tx_len_d   = tx_len_q;
        tx_valid_d = 1'b0;
        tx_last_d  = 1'b0;
        tx_src_d   = tx_src_q;
        src_take   = '0;
        take_len   = '0;

        case (state_q)
            ST_IDLE: begin
                if (w_found) begin
                    rr_ptr_d = w_next_ptr;
                    if (w_len_bad) begin
                        err_d[w_pick] = 1'b1;
                    end else begin
                        sel_d   = w_pick;
                        rem_d   = w_pick_len;
                        state_d = ST_SEND;
                    end
                end
            end
            ST_SEND: begin
                if (w_n != 7'd0) begin
                    src_take[sel_q] = 1'b1;
                    take_len        = w_n;
                    tx_data_d       = w_data_arr[sel_q] & w_mask;
                    tx_len_d        = w_n;
                    tx_valid_d      = 1'b1;
                    tx_src_d        = sel_q;
                    rem_d           = rem_q - LEN_W'(w_n);
                    if (w_slot_c >= w_rem_c) begin
                        tx_last_d     = 1'b1;
                        done_d[sel_q] = 1'b1;
                        state_d       = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            rr_ptr_q   <= '0;
            sel_q      <= '0;
            rem_q      <= '0;
            done_q     <= '0;
            err_q      <= '0;
            tx_data_q  <= '0;
            tx_len_q   <= '0;
            tx_valid_q <= 1'b0;
            tx_last_q  <= 1'b0;
            tx_src_q   <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            sel_q      <= sel_d;
            rem_q      <= rem_d;
            done_q     <= done_d;
            err_q      <= err_d;
            tx_data_q  <= tx_data_d;
            tx_len_q   <= tx_len_d;
            tx_valid_q <= tx_valid_d;
            tx_last_q  <= tx_last_d;
            tx_src_q   <= tx_src_d;
        end
    end

    assign src_done    = done_q;
    assign src_err     = err_q;
    assign tx_ipg_data = tx_data_q;
    assign tx_len      = tx_len_q;
    assign tx_valid    = tx_valid_q;
    assign tx_last     = tx_last_q;
    assign tx_src      = tx_src_q;

endmodule

`default_nettype wire

// File: tb/tb_ipg_tx_sched.sv
// tb_ipg_tx_sched: directed table, hand sequences and randomized traffic against a message-level reference.
`default_nettype none

module tb_ipg_tx_sched;

    localparam int NS   = 3;
    localparam int LW   = 10;
    localparam int MAXB = 528;

    logic             clk = 1'b0;
    logic             reset;
    logic [6:0]       slot_len;
    logic [NS-1:0]    src_req;
    logic [NS*LW-1:0] src_len;
    logic [NS*64-1:0] src_data;
    logic [NS-1:0]    src_take, src_done, src_err;
    logic [6:0]       take_len, tx_len;
    logic [63:0]      tx_ipg_data;
    logic             tx_valid, tx_last;
    logic [1:0]       tx_src;

    always #5 clk = ~clk;

    ipg_tx_sched #(.NUM_SRC(NS), .LEN_W(LW), .MAX_MSG_BITS(MAXB)) u_dut (
        .clk(clk), .reset(reset), .slot_len(slot_len), .src_req(src_req), .src_len(src_len),
        .src_data(src_data), .src_take(src_take), .take_len(take_len), .src_done(src_done),
        .src_err(src_err), .tx_ipg_data(tx_ipg_data), .tx_len(tx_len), .tx_valid(tx_valid),
        .tx_last(tx_last), .tx_src(tx_src)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Source side: each source holds its whole message, first bit at bit 527.
    logic [527:0] msg [NS];
    int           off [NS];
    int           reload_left [NS];
    int           reload_len [NS];
    bit           rnd_mode;

    // Reference: message-level bookkeeping of who owns the channel and how much is left.
    bit            busy;
    int            rsel, rrem, rptr;
    int            roff [NS];
    logic [NS-1:0] e_take, e_done, e_err;
    logic [6:0]    e_tlen, e_len;
    logic [63:0]   e_data;
    logic          e_valid, e_last;
    logic [1:0]    e_src;

    int            slot_mode, slot_const, cyc;
    int            pat [5] = '{0, 13, 0, 64, 7};
    int            n_chunks, sum_len;
    int            last_q [$];
    logic [NS-1:0] done_seen, err_seen;

    function automatic logic [63:0] win(input int s, input int o);
        logic [527:0] t;
        t = msg[s] << o;
        return t[527:464];
    endfunction

    function automatic logic [63:0] keep_top(input logic [63:0] d, input int n);
        logic [63:0] r;
        r = '0;
        for (int b = 0; b < n; b++) r[63-b] = d[63-b];
        return r;
    endfunction

    function automatic int rand_len();
        int r;
        r = int'($urandom_range(0, 11));
        if (r == 0) return ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(529, 1023));
        if (r < 6) return int'($urandom_range(1, 80));
        return int'($urandom_range(1, 528));
    endfunction

    task automatic load(input int i, input int len);
        logic [543:0] tmp;
        for (int w = 0; w < 17; w++) tmp[w*32 +: 32] = $urandom;
        msg[i] = tmp[527:0];
        off[i] = 0;
        src_len[i*LW +: LW] = LW'(len);
        src_req[i] = 1'b1;
    endtask

    task automatic drive();
        for (int i = 0; i < NS; i++) src_data[i*64 +: 64] = win(i, off[i]);
    endtask

    task automatic ref_reset();
        busy = 1'b0; rsel = 0; rrem = 0; rptr = 0;
        e_take = '0; e_done = '0; e_err = '0; e_tlen = '0; e_len = '0;
        e_data = '0; e_valid = 1'b0; e_last = 1'b0; e_src = '0;
        for (int i = 0; i < NS; i++) roff[i] = 0;
    endtask

    task automatic ref_step();
        int  s, n, idx, l;
        bit  found;
        e_take = '0; e_tlen = '0; e_valid = 1'b0; e_last = 1'b0; e_done = '0; e_err = '0;
        if (!busy) begin
            found = 1'b0;
            for (int k = 0; k < NS; k++) begin
                idx = (rptr + k) % NS;
                if (!found && src_req[idx]) begin
                    found = 1'b1;
                    l = int'(src_len[idx*LW +: LW]);
                    if (l == 0 || l > MAXB) e_err[idx] = 1'b1;
                    else begin
                        busy = 1'b1; rsel = idx; rrem = l; roff[idx] = 0;
                    end
                    rptr = (idx + 1) % NS;
                end
            end
        end else begin
            s = (int'(slot_len) > 64) ? 64 : int'(slot_len);
            n = (s < rrem) ? s : rrem;
            if (n > 0) begin
                e_take[rsel] = 1'b1; e_tlen = 7'(n); e_valid = 1'b1; e_len = 7'(n); e_src = 2'(rsel);
                e_data = keep_top(win(rsel, roff[rsel]), n);
                roff[rsel] += n;
                rrem -= n;
                if (rrem == 0) begin
                    e_last = 1'b1; e_done[rsel] = 1'b1; busy = 1'b0;
                end
            end
        end
    endtask

    task automatic src_react();
        for (int i = 0; i < NS; i++) begin
            if (src_done[i] || src_err[i]) begin
                if (reload_left[i] > 0) begin
                    reload_left[i]--;
                    load(i, rnd_mode ? rand_len() : reload_len[i]);
                end else begin
                    src_req[i] = 1'b0;
                end
            end
        end
        if (rnd_mode) begin
            for (int i = 0; i < NS; i++)
                if (!src_req[i] && $urandom_range(0, 3) == 0) load(i, rand_len());
        end
    endtask

    // One clock: apply inputs after a falling edge, check combinational takes, then registered outputs.
    task automatic cycle();
        logic [NS-1:0] tk;
        int            tl, r;
        case (slot_mode)
            0: slot_len = 7'(slot_const);
            1: slot_len = 7'(pat[cyc % 5]);
            default: begin
                r = int'($urandom_range(0, 9));
                slot_len = (r == 0) ? 7'd0 : (r == 1) ? 7'd64 : 7'($urandom_range(1, 64));
            end
        endcase
        drive();
        #1;
        ref_step();
        chk("take_len", 64'(take_len), 64'(e_tlen));
        chk("src_take", 64'(src_take), 64'(e_take));
        tk = src_take;
        tl = int'(take_len);
        @(posedge clk);
        for (int i = 0; i < NS; i++) if (tk[i]) off[i] += tl;
        @(negedge clk);
        chk("tx_valid", 64'(tx_valid), 64'(e_valid));
        chk("tx_last", 64'(tx_last), 64'(e_last));
        chk("tx_len", 64'(tx_len), 64'(e_len));
        chk("tx_data", tx_ipg_data, e_data);
        if (e_valid) chk("tx_src", 64'(tx_src), 64'(e_src));
        chk("src_done", 64'(src_done), 64'(e_done));
        chk("src_err", 64'(src_err), 64'(e_err));
        if (tx_valid) begin
            n_chunks++;
            sum_len += int'(tx_len);
        end
        if (tx_last) last_q.push_back(int'(tx_src));
        done_seen |= src_done;
        err_seen  |= src_err;
        src_react();
        cyc++;
    endtask

    task automatic run_idle(input int budget);
        int k;
        k = 0;
        while ((src_req != '0 || busy) && k < budget) begin
            cycle();
            k++;
        end
        chk("drain_timeout", 64'((src_req != '0 || busy) ? 1 : 0), 64'd0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"}, 64'(tx_valid), 64'd0);
        chk({tag, "_last"},  64'(tx_last), 64'd0);
        chk({tag, "_len"},   64'(tx_len), 64'd0);
        chk({tag, "_data"},  tx_ipg_data, 64'd0);
        chk({tag, "_src"},   64'(tx_src), 64'd0);
        chk({tag, "_done"},  64'(src_done), 64'd0);
        chk({tag, "_err"},   64'(src_err), 64'd0);
        chk({tag, "_take"},  64'(src_take), 64'd0);
        chk({tag, "_tlen"},  64'(take_len), 64'd0);
    endtask

    task automatic clear_env();
        src_req = '0;
        for (int i = 0; i < NS; i++) begin
            off[i] = 0; reload_left[i] = 0; reload_len[i] = 0;
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        chk_zero("rst");
        clear_env();
        ref_reset();
        @(negedge clk);
        reset = 1'b1;
    endtask

    typedef struct {
        logic [2:0] req;
        int         l0, l1, l2;
        int         slot;
        logic [2:0] x_err;
        int         x_chunks;
    } vec_t;

    vec_t tab [8];

    initial begin
        int k;
        tab[0] = '{3'b010, 0,   100, 0,   64, 3'b000, 2};
        tab[1] = '{3'b111, 40,  40,  40,  64, 3'b000, 3};
        tab[2] = '{3'b011, 0,   600, 0,   64, 3'b011, 0};
        tab[3] = '{3'b001, 64,  0,   0,   64, 3'b000, 1};
        tab[4] = '{3'b100, 0,   0,   528, 64, 3'b000, 9};
        tab[5] = '{3'b101, 1,   0,   65,  7,  3'b000, 11};
        tab[6] = '{3'b111, 0,   529, 528, 64, 3'b011, 9};
        tab[7] = '{3'b110, 0,   127, 128, 32, 3'b000, 8};

        reset = 1'b0; slot_len = '0; src_len = '0; src_data = '0;
        rnd_mode = 1'b0; slot_mode = 0; slot_const = 64; cyc = 0;
        n_chunks = 0; sum_len = 0; done_seen = '0; err_seen = '0;
        for (int i = 0; i < NS; i++) msg[i] = '0;
        clear_env();
        ref_reset();
        @(negedge clk);
        @(negedge clk);
        chk_zero("init");
        reset = 1'b1;

        // Three equal requesters, src0 comes back once: completion order 0,1,2,0.
        last_q.delete();
        reload_left[0] = 1; reload_len[0] = 40;
        for (int i = 0; i < NS; i++) load(i, 40);
        run_idle(100);
        chk("rr_order_n", 64'(last_q.size()), 64'd4);
        chk("rr_order0", 64'((last_q.size() > 0) ? last_q[0] : 9), 64'd0);
        chk("rr_order1", 64'((last_q.size() > 1) ? last_q[1] : 9), 64'd1);
        chk("rr_order2", 64'((last_q.size() > 2) ? last_q[2] : 9), 64'd2);
        chk("rr_order3", 64'((last_q.size() > 3) ? last_q[3] : 9), 64'd0);

        // Single 100-bit message on src1: grant, 64, 36 with last and done.
        load(1, 100);
        cycle();
        chk("t1_grant_valid", 64'(tx_valid), 64'd0);
        cycle();
        chk("t1_len_a", 64'(tx_len), 64'd64);
        chk("t1_last_a", 64'(tx_last), 64'd0);
        cycle();
        chk("t1_len_b", 64'(tx_len), 64'd36);
        chk("t1_last_b", 64'(tx_last), 64'd1);
        chk("t1_done", 64'(src_done), 64'b010);
        run_idle(20);

        for (int t = 0; t < 8; t++) begin
            n_chunks = 0; err_seen = '0; slot_mode = 0; slot_const = tab[t].slot;
            if (tab[t].req[0]) load(0, tab[t].l0);
            if (tab[t].req[1]) load(1, tab[t].l1);
            if (tab[t].req[2]) load(2, tab[t].l2);
            run_idle(300);
            chk("tab_chunks", 64'(n_chunks), 64'(tab[t].x_chunks));
            chk("tab_err", 64'(err_seen), 64'(tab[t].x_err));
        end

        // Irregular slot pattern including empty slots on a maximum-size message.
        slot_mode = 1; cyc = 0; sum_len = 0;
        load(2, 528);
        run_idle(400);
        chk("t3_sum", 64'(sum_len), 64'd528);

        // Request dropped mid-message: the message still completes.
        slot_mode = 0; slot_const = 64; done_seen = '0;
        load(0, 200);
        cycle();
        cycle();
        src_req[0] = 1'b0;
        k = 0;
        while (busy && k < 10) begin
            cycle();
            k++;
        end
        chk("t6_done", 64'(done_seen[0]), 64'd1);

        // Reset in the middle of a 300-bit message after 128 bits.
        sum_len = 0;
        load(1, 300);
        cycle(); cycle(); cycle();
        chk("t5_sent", 64'(sum_len), 64'd128);
        do_reset();
        last_q.delete();
        for (int i = 0; i < NS; i++) load(i, 50);
        run_idle(100);
        chk("t5_first", 64'((last_q.size() > 0) ? last_q[0] : 9), 64'd0);

        // Random traffic, then drain.
        rnd_mode = 1'b1; slot_mode = 2;
        for (int c = 0; c < 3000; c++) cycle();
        rnd_mode = 1'b0;
        for (int i = 0; i < NS; i++) reload_left[i] = 0;
        run_idle(2000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
